mem_access_unit: RTL and testbench

Load/store front end between the CPU core and `Cache`. Accepts byte, half-word and word requests at any byte address, applies alignment, byte masking and sign/zero extension, and splits accesses that straddle a 32-bit word boundary into two cache accesses. Drives `Cache`'s word port (`address`, `data_in`, `write_enable`) and consumes `data_out`, `data_out_ready` and `busy`.

---
 rtl/mem_access_unit_pkg.sv | 33 +++
 rtl/mem_access_unit_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store front end: access size codes,
// FSM state encoding and small size helpers.
package MemAccessPkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    CHECK = 2'b10,
    RESP  = 2'b11
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_mask = 4'b0001;
      SIZE_HALF: size_mask = 4'b0011;
      default:   size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational byte-lane logic: positions store data and masks across two
// words, flags word-straddling accesses, and extracts/extends load data.
module mem_align
  import MemAccessPkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  output logic [31:0] lane_data0,
  output logic [31:0] lane_data1,
  output logic [3:0]  lane_mask0,
  output logic [3:0]  lane_mask1,
  output logic        split,
  output logic [31:0] load_data
);

  logic [31:0] wdata_trunc;
  logic [63:0] lane_data;
  logic [7:0]  lane_mask;
  logic [2:0]  span_end;
  logic [31:0] shifted;

  always_comb begin
    case (size)
      SIZE_BYTE: wdata_trunc = {24'h0, wdata[7:0]};
      SIZE_HALF: wdata_trunc = {16'h0, wdata[15:0]};
      default:   wdata_trunc = wdata;
    endcase

    lane_data = {32'h0, wdata_trunc} << {off, 3'b000};
    lane_mask = {4'h0, size_mask(size)} << off;
    span_end  = {1'b0, off} + size_bytes(size);

    // Upper bytes of the pair fall off the truncation, so w1 only matters when split
    shifted = 32'({w1, w0} >> {off, 3'b000});
    case (size)
      SIZE_BYTE: load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

  assign lane_data0 = lane_data[31:0];
  assign lane_data1 = lane_data[63:32];
  assign lane_mask0 = lane_mask[3:0];
  assign lane_mask1 = lane_mask[7:4];
  assign split      = (span_end > 3'd4);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-wide Cache port: sequences one or two
// cache accesses per request and returns an extended load result.
module mem_access_unit
  import MemAccessPkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] c_address,
  output logic [31:0] c_data_in,
  output logic [3:0]  c_write_enable,
  input  logic [31:0] c_data_out,
  input  logic        c_data_out_ready,
  input  logic        c_busy
);

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] c_address_q, c_address_d;
  logic [31:0] c_data_in_q, c_data_in_d;
  logic [3:0]  c_we_q, c_we_d;

  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic        split_q, split_d;
  logic        phase1_q, phase1_d;
  logic [31:0] addr1_q, addr1_d;
  logic [31:0] data1_q, data1_d;
  logic [3:0]  mask1_q, mask1_d;
  logic [31:0] w0_q, w0_d;

  logic [1:0]  al_off;
  logic [1:0]  al_size;
  logic        al_signed;
  logic [31:0] al_w0;
  logic [31:0] lane_data0, lane_data1;
  logic [3:0]  lane_mask0, lane_mask1;
  logic        al_split;
  logic [31:0] load_data;
  logic        accept;
  logic        done;

  // Live request fields drive the aligner while idle, latched copies afterwards
  assign al_off    = (state_q == IDLE) ? req_addr[1:0] : off_q;
  assign al_size   = (state_q == IDLE) ? req_size      : size_q;
  assign al_signed = (state_q == IDLE) ? req_signed    : signed_q;
  assign al_w0     = phase1_q ? w0_q : c_data_out;

  mem_align u_align (
    .off        (al_off),
    .size       (al_size),
    .is_signed  (al_signed),
    .wdata      (req_wdata),
    .w0         (al_w0),
    .w1         (c_data_out),
    .lane_data0 (lane_data0),
    .lane_data1 (lane_data1),
    .lane_mask0 (lane_mask0),
    .lane_mask1 (lane_mask1),
    .split      (al_split),
    .load_data  (load_data)
  );

  assign accept = req_valid && req_ready_q;
  assign done   = write_q ? !c_busy : c_data_out_ready;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_error_d = 1'b0;
    c_address_d = c_address_q;
    c_data_in_d = c_data_in_q;
    c_we_d      = c_we_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    off_d       = off_q;
    split_d     = split_q;
    phase1_d    = phase1_q;
    addr1_d     = addr1_q;
    data1_d     = data1_q;
    mask1_d     = mask1_q;
    w0_d        = w0_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          if (req_size == SIZE_ILLEGAL) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            state_d     = RESP;
          end else begin
            write_d     = req_write;
            size_d      = req_size;
            signed_d    = req_signed;
            off_d       = req_addr[1:0];
            split_d     = al_split;
            phase1_d    = 1'b0;
            addr1_d     = {req_addr[31:2], 2'b00} + 32'd4;
            data1_d     = lane_data1;
            mask1_d     = lane_mask1;
            c_address_d = {req_addr[31:2], 2'b00};
            c_data_in_d = req_write ? lane_data0 : 32'h0;
            c_we_d      = req_write ? lane_mask0 : 4'h0;
            state_d     = ISSUE;
          end
        end
      end

      ISSUE: state_d = CHECK;

      CHECK: begin
        if (done) begin
          if (!phase1_q) w0_d = c_data_out;
          // A zero upper mask means the access fit in one word
          if (split_q && !phase1_q) begin
            phase1_d    = 1'b1;
            c_address_d = addr1_q;
            c_data_in_d = write_q ? data1_q : 32'h0;
            c_we_d      = write_q ? mask1_q : 4'h0;
            state_d     = ISSUE;
          end else begin
            c_we_d      = 4'h0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = write_q ? 32'h0 : load_data;
            state_d     = RESP;
          end
        end
      end

      RESP: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
      c_address_q <= 32'h0;
      c_data_in_q <= 32'h0;
      c_we_q      <= 4'h0;
      write_q     <= 1'b0;
      size_q      <= SIZE_BYTE;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
      split_q     <= 1'b0;
      phase1_q    <= 1'b0;
      addr1_q     <= 32'h0;
      data1_q     <= 32'h0;
      mask1_q     <= 4'h0;
      w0_q        <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      c_address_q <= c_address_d;
      c_data_in_q <= c_data_in_d;
      c_we_q      <= c_we_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
      split_q     <= split_d;
      phase1_q    <= phase1_d;
      addr1_q     <= addr1_d;
      data1_q     <= data1_d;
      mask1_q     <= mask1_d;
      w0_q        <= w0_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;
  assign c_address      = c_address_q;
  assign c_data_in      = c_data_in_q;
  assign c_write_enable = c_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a small word-cache model with
// per-word fill latency (longer for the evicting region at 64 and above).
module tb_mem_access_unit;
  import MemAccessPkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] c_address;
  logic [31:0] c_data_in;
  logic [3:0]  c_write_enable;
  logic [31:0] c_data_out;
  logic        c_data_out_ready;
  logic        c_busy;

  int test_count = 0;
  int fail_count = 0;

  mem_access_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .c_address        (c_address),
    .c_data_in        (c_data_in),
    .c_write_enable   (c_write_enable),
    .c_data_out       (c_data_out),
    .c_data_out_ready (c_data_out_ready),
    .c_busy           (c_busy)
  );

  always #5 clk = ~clk;

  // Cache model: a word is ready once filled; writes land only on filled words
  logic [31:0] mem    [0:63];
  logic        cached [0:63];
  logic        model_ready = 1'b0;
  int          fill_cnt;
  logic [5:0]  idx;

  assign idx              = c_address[7:2];
  assign c_data_out       = mem[idx];
  assign c_data_out_ready = model_ready && cached[idx];
  assign c_busy           = !(model_ready && cached[idx]);

  always @(posedge clk) begin
    if (!model_ready) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]    <= 32'h0;
        cached[i] <= 1'b0;
      end
      mem[0]      <= 32'h55667788;
      mem[2]      <= 32'hAB4C3E6F;
      mem[3]      <= 32'h9D8E2F17;
      mem[4]      <= 32'hD5B8A9C4;
      mem[63]     <= 32'h11223344;
      cached[0]   <= 1'b1;
      fill_cnt    <= 0;
      model_ready <= 1'b1;
    end else if (!cached[idx]) begin
      if (fill_cnt >= ((idx >= 6'd16) ? 5 : 2)) begin
        cached[idx] <= 1'b1;
        fill_cnt    <= 0;
      end else begin
        fill_cnt <= fill_cnt + 1;
      end
    end else begin
      fill_cnt <= 0;
      for (int b = 0; b < 4; b++)
        if (c_write_enable[b]) mem[idx][8*b +: 8] <= c_data_in[8*b +: 8];
    end
  end

  int          lat;
  logic        got_valid;
  logic [31:0] got_rdata;
  logic        got_error;
  int          n_addr;
  logic [31:0] addr_log [0:3];
  int          n_we;
  logic [3:0]  we_log [0:3];
  logic        no_rsp;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request and records what the cache port did until the response
  task automatic apply_stimulus(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat       = 0;
    n_addr    = 0;
    n_we      = 0;
    got_valid = 1'b0;
    got_rdata = 32'hX;
    got_error = 1'bX;
    while (!got_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (n_addr < 4 && (n_addr == 0 || c_address !== addr_log[n_addr-1])) begin
        addr_log[n_addr] = c_address;
        n_addr++;
      end
      if (n_we < 4 && c_write_enable != 4'h0 && (n_we == 0 || c_write_enable !== we_log[n_we-1])) begin
        we_log[n_we] = c_write_enable;
        n_we++;
      end
      if (rsp_valid) begin
        got_valid = 1'b1;
        got_rdata = rsp_rdata;
        got_error = rsp_error;
      end
    end
    check_output("rsp_seen", {31'h0, got_valid}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = SIZE_BYTE;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (2) @(negedge clk);

    check_output("rst_req_ready", {31'h0, req_ready}, 32'd1);
    check_output("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_output("rst_rsp_error", {31'h0, rsp_error}, 32'd0);
    check_output("rst_c_address", c_address, 32'h0);
    check_output("rst_c_data_in", c_data_in, 32'h0);
    check_output("rst_c_we", {28'h0, c_write_enable}, 32'h0);
    rst_n = 1'b1;

    apply_stimulus(1'b0, SIZE_BYTE, 1'b0, 32'd9, 32'h0);
    check_output("lb9_data", got_rdata, 32'h0000003E);
    check_output("lb9_err", {31'h0, got_error}, 32'd0);
    check_output("lb9_miss_slow", {31'h0, lat > 3}, 32'd1);
    @(negedge clk);
    check_output("pulse_drop", {31'h0, rsp_valid}, 32'd0);
    check_output("ready_back", {31'h0, req_ready}, 32'd1);

    apply_stimulus(1'b0, SIZE_BYTE, 1'b1, 32'd11, 32'h0);
    check_output("lb11s_data", got_rdata, 32'hFFFFFFAB);
    check_output("lb11s_lat", 32'(lat), 32'd3);

    apply_stimulus(1'b0, SIZE_WORD, 1'b0, 32'd10, 32'h0);
    check_output("lw10_miss_data", got_rdata, 32'h2F17AB4C);

    apply_stimulus(1'b0, SIZE_WORD, 1'b0, 32'd10, 32'h0);
    check_output("lw10_data", got_rdata, 32'h2F17AB4C);
    check_output("lw10_lat", 32'(lat), 32'd5);
    check_output("lw10_n_addr", 32'(n_addr), 32'd2);
    check_output("lw10_addr0", addr_log[0], 32'd8);
    check_output("lw10_addr1", addr_log[1], 32'd12);

    apply_stimulus(1'b1, SIZE_HALF, 1'b0, 32'd15, 32'h1234BEEF);
    check_output("sh15_rdata", got_rdata, 32'h0);
    check_output("sh15_n_we", 32'(n_we), 32'd2);
    check_output("sh15_we0", {28'h0, we_log[0]}, 32'h8);
    check_output("sh15_we1", {28'h0, we_log[1]}, 32'h1);
    check_output("sh15_addr1", addr_log[1], 32'd16);
    check_output("we_idle", {28'h0, c_write_enable}, 32'h0);

    apply_stimulus(1'b0, SIZE_WORD, 1'b0, 32'd12, 32'h0);
    check_output("lw12_data", got_rdata, 32'hEF8E2F17);
    check_output("lw12_lat", 32'(lat), 32'd3);
    apply_stimulus(1'b0, SIZE_WORD, 1'b0, 32'd16, 32'h0);
    check_output("lw16_data", got_rdata, 32'hD5B8A9BE);
    apply_stimulus(1'b0, SIZE_HALF, 1'b1, 32'd15, 32'h0);
    check_output("lh15s_data", got_rdata, 32'hFFFFBEEF);
    check_output("lh15s_lat", 32'(lat), 32'd5);
    apply_stimulus(1'b0, SIZE_HALF, 1'b0, 32'd15, 32'h0);
    check_output("lh15u_data", got_rdata, 32'h0000BEEF);
    apply_stimulus(1'b0, SIZE_HALF, 1'b1, 32'd14, 32'h0);
    check_output("lh14s_data", got_rdata, 32'hFFFFEF8E);
    apply_stimulus(1'b0, SIZE_BYTE, 1'b0, 32'd16, 32'h0);
    check_output("lb16u_data", got_rdata, 32'h000000BE);

    apply_stimulus(1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'h1234565A);
    check_output("sb21_we0", {28'h0, we_log[0]}, 32'h2);
    check_output("sb21_data_in", c_data_in, 32'h00005A00);
    apply_stimulus(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0);
    check_output("lw20_data", got_rdata, 32'h00005A00);

    apply_stimulus(1'b1, SIZE_WORD, 1'b0, 32'd64, 32'hABCDEF12);
    check_output("sw64_rdata", got_rdata, 32'h0);
    check_output("sw64_busy_slow", {31'h0, lat > 5}, 32'd1);
    check_output("sw64_we0", {28'h0, we_log[0]}, 32'hF);
    apply_stimulus(1'b0, SIZE_WORD, 1'b0, 32'd64, 32'h0);
    check_output("lw64_data", got_rdata, 32'hABCDEF12);
    check_output("lw64_lat", 32'(lat), 32'd3);

    apply_stimulus(1'b0, SIZE_ILLEGAL, 1'b0, 32'd8, 32'h0);
    check_output("ill_err", {31'h0, got_error}, 32'd1);
    check_output("ill_rdata", got_rdata, 32'h0);
    check_output("ill_lat", 32'(lat), 32'd1);
    check_output("ill_n_we", 32'(n_we), 32'd0);
    check_output("ill_c_address", c_address, 32'd64);

    apply_stimulus(1'b0, SIZE_WORD, 1'b0, 32'hFFFFFFFE, 32'h0);
    check_output("wrap_data", got_rdata, 32'h77881122);
    check_output("wrap_addr0", addr_log[0], 32'hFFFFFFFC);
    check_output("wrap_addr1", addr_log[1], 32'h0);

    // Split load at 26 misses on word 24, so CHECK lasts several cycles
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_size   = SIZE_WORD;
    req_signed = 1'b0;
    req_addr   = 32'd26;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("pre_rst_c_address", c_address, 32'd24);
    rst_n = 1'b0;
    #1;
    check_output("arst_req_ready", {31'h0, req_ready}, 32'd1);
    check_output("arst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check_output("arst_c_address", c_address, 32'h0);
    check_output("arst_c_we", {28'h0, c_write_enable}, 32'h0);
    check_output("arst_rsp_rdata", rsp_rdata, 32'h0);
    no_rsp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) no_rsp = 1'b0;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) no_rsp = 1'b0;
    end
    check_output("arst_no_rsp", {31'h0, no_rsp}, 32'd1);

    apply_stimulus(1'b0, SIZE_WORD, 1'b0, 32'd8, 32'h0);
    check_output("post_rst_lw8", got_rdata, 32'hAB4C3E6F);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
